// File: rtl/xtal_osc_16m_supervisor_pkg.sv
// rtl/xtal_osc_16m_supervisor_pkg.sv - state encoding and default constants for the 16 MHz crystal supervisor
package xtal_osc_16m_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_READY   = 3'd3,
        ST_STDBY   = 3'd4,
        ST_FAULT   = 3'd5
    } sup_state_t;

    localparam int unsigned DEF_STARTUP_CYC = 65536;
    localparam int unsigned DEF_WIN_CYC     = 1024;
    localparam int unsigned DEF_EDGE_MIN    = 320;
    localparam int unsigned DEF_EDGE_MAX    = 336;
    localparam int unsigned DEF_GOOD_WINS   = 4;
    localparam int unsigned DEF_LOSS_CYC    = 16;
    localparam int unsigned DEF_RETRY_MAX   = 3;
    localparam int unsigned DEF_CNTW        = 16;

    // Counter width able to hold values 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/xtal_edge_sync.sv
// rtl/xtal_edge_sync.sv - 2-FF synchronizer plus registered rising-edge pulse for the crystal output
module xtal_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d_async,
    output logic edge_pulse
);

    logic meta_q;
    logic sync_q;
    logic sync_d_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_d_q   <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            meta_q     <= d_async;
            sync_q     <= meta_q;
            sync_d_q   <= sync_q;
            edge_pulse <= sync_q & ~sync_d_q;
        end
    end

endmodule

// File: rtl/xtal_osc_16m_supervisor.sv
// rtl/xtal_osc_16m_supervisor.sv - crystal enable/standby control, frequency qualification and loss monitor
module xtal_osc_16m_supervisor
    import xtal_osc_16m_supervisor_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = DEF_STARTUP_CYC,
    parameter int unsigned WIN_CYC     = DEF_WIN_CYC,
    parameter int unsigned EDGE_MIN    = DEF_EDGE_MIN,
    parameter int unsigned EDGE_MAX    = DEF_EDGE_MAX,
    parameter int unsigned GOOD_WINS   = DEF_GOOD_WINS,
    parameter int unsigned LOSS_CYC    = DEF_LOSS_CYC,
    parameter int unsigned RETRY_MAX   = DEF_RETRY_MAX,
    parameter int unsigned CNTW        = DEF_CNTW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en_req,
    input  logic            stdby_req,
    input  logic            xtal_dout,
    output logic            xtal_ena,
    output logic            xtal_stdby,
    output logic            clk_ready,
    output logic            fault,
    output logic [2:0]      state,
    output logic [CNTW-1:0] edge_count
);

    localparam int unsigned TMAX = (STARTUP_CYC > WIN_CYC) ? STARTUP_CYC : WIN_CYC;
    localparam int unsigned TW   = cnt_width(TMAX - 1);
    localparam int unsigned GW   = cnt_width(GOOD_WINS);
    localparam int unsigned LW   = cnt_width(LOSS_CYC);
    localparam int unsigned RW   = cnt_width(RETRY_MAX);

    sup_state_t     st;
    logic [TW-1:0]  timer;
    logic [CNTW-1:0] edge_cnt;
    logic [GW-1:0]  good_cnt;
    logic [LW-1:0]  loss_cnt;
    logic [RW-1:0]  retry_cnt;

    logic           edge_pulse;
    logic [CNTW-1:0] edge_sum;
    logic           win_end;
    logic           start_done;
    logic           in_range;
    logic           loss_hit;
    logic           retry_exhausted;

    xtal_edge_sync u_edge_sync (
        .clk        (clk),
        .resetn     (resetn),
        .d_async    (xtal_dout),
        .edge_pulse (edge_pulse)
    );

    // edge_sum already includes an edge landing on the closing cycle of a window.
    always_comb begin
        edge_sum        = edge_cnt;
        if (edge_pulse && (edge_cnt != {CNTW{1'b1}})) begin
            edge_sum = edge_cnt + CNTW'(1);
        end
        win_end         = (timer == TW'(WIN_CYC - 1));
        start_done      = (timer == TW'(STARTUP_CYC - 1));
        in_range        = (edge_sum >= CNTW'(EDGE_MIN)) && (edge_sum <= CNTW'(EDGE_MAX));
        loss_hit        = !edge_pulse && (loss_cnt == LW'(LOSS_CYC - 1));
        retry_exhausted = (retry_cnt == RW'(RETRY_MAX));
    end

    assign state = st;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st         <= ST_OFF;
            timer      <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            loss_cnt   <= '0;
            retry_cnt  <= '0;
            xtal_ena   <= 1'b0;
            xtal_stdby <= 1'b0;
            clk_ready  <= 1'b0;
            fault      <= 1'b0;
            edge_count <= '0;
        end else if (!en_req) begin
            st         <= ST_OFF;
            timer      <= '0;
            retry_cnt  <= '0;
            xtal_ena   <= 1'b0;
            xtal_stdby <= 1'b0;
            clk_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (st)
                ST_OFF: begin
                    st       <= ST_START;
                    timer    <= '0;
                    xtal_ena <= 1'b1;
                end

                ST_START: begin
                    timer <= timer + TW'(1);
                    if (start_done) begin
                        st       <= ST_MEASURE;
                        timer    <= '0;
                        edge_cnt <= '0;
                        good_cnt <= '0;
                    end
                end

                ST_MEASURE: begin
                    edge_cnt <= edge_sum;
                    timer    <= timer + TW'(1);
                    if (win_end) begin
                        edge_count <= edge_sum;
                        edge_cnt   <= '0;
                        timer      <= '0;
                        if (in_range) begin
                            if (good_cnt == GW'(GOOD_WINS - 1)) begin
                                st        <= ST_READY;
                                clk_ready <= 1'b1;
                                retry_cnt <= '0;
                                loss_cnt  <= '0;
                            end else begin
                                good_cnt <= good_cnt + GW'(1);
                            end
                        end else if (retry_exhausted) begin
                            st       <= ST_FAULT;
                            xtal_ena <= 1'b0;
                            fault    <= 1'b1;
                        end else begin
                            st        <= ST_START;
                            retry_cnt <= retry_cnt + RW'(1);
                        end
                    end
                end

                ST_READY: begin
                    edge_cnt <= edge_sum;
                    timer    <= timer + TW'(1);
                    loss_cnt <= edge_pulse ? '0 : loss_cnt + LW'(1);
                    if (win_end) begin
                        edge_count <= edge_sum;
                        edge_cnt   <= '0;
                        timer      <= '0;
                    end
                    // Loss or a bad window outranks a standby request.
                    if (loss_hit || (win_end && !in_range)) begin
                        clk_ready <= 1'b0;
                        timer     <= '0;
                        if (retry_exhausted) begin
                            st       <= ST_FAULT;
                            xtal_ena <= 1'b0;
                            fault    <= 1'b1;
                        end else begin
                            st        <= ST_START;
                            retry_cnt <= retry_cnt + RW'(1);
                        end
                    end else if (stdby_req) begin
                        st         <= ST_STDBY;
                        clk_ready  <= 1'b0;
                        xtal_stdby <= 1'b1;
                    end
                end

                ST_STDBY: begin
                    if (!stdby_req) begin
                        st         <= ST_START;
                        timer      <= '0;
                        xtal_stdby <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    xtal_ena <= 1'b0;
                    fault    <= 1'b1;
                end

                default: begin
                    st <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xtal_osc_16m_supervisor.sv
// tb/tb_xtal_osc_16m_supervisor.sv - directed bench with behavioural supervisor model and oscillator model
`timescale 1ns/1ps
module tb_xtal_osc_16m_supervisor;

    localparam int STARTUP = 64;
    localparam int WIN     = 64;
    localparam int EMIN    = 19;
    localparam int EMAX    = 22;
    localparam int GOOD    = 4;
    localparam int LOSS    = 16;
    localparam int RMAX    = 3;
    localparam int CNTW    = 16;
    localparam int CMAX    = (1 << CNTW) - 1;

    localparam int P_OFF = 0, P_START = 1, P_MEAS = 2, P_READY = 3, P_STDBY = 4, P_FAULT = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en_req = 1'b0;
    logic stdby_req = 1'b0;
    logic osc = 1'b0;
    logic xtal_stop = 1'b0;
    logic xtal_dout;
    logic xtal_ena, xtal_stdby, clk_ready, fault;
    logic [2:0] state;
    logic [CNTW-1:0] edge_count;
    real  half_ns = 31.25;

    int checks = 0;
    int failures = 0;
    logic saw_ready = 1'b0;

    xtal_osc_16m_supervisor #(
        .STARTUP_CYC (STARTUP), .WIN_CYC (WIN), .EDGE_MIN (EMIN), .EDGE_MAX (EMAX),
        .GOOD_WINS (GOOD), .LOSS_CYC (LOSS), .RETRY_MAX (RMAX), .CNTW (CNTW)
    ) dut (
        .clk (clk), .resetn (resetn), .en_req (en_req), .stdby_req (stdby_req),
        .xtal_dout (xtal_dout), .xtal_ena (xtal_ena), .xtal_stdby (xtal_stdby),
        .clk_ready (clk_ready), .fault (fault), .state (state), .edge_count (edge_count)
    );

    initial forever #10 clk = ~clk;
    // Oscillator phase offset keeps its edges off the reference clock edges.
    initial begin
        #1;
        forever #(half_ns) osc = ~osc;
    end
    assign xtal_dout = osc & xtal_ena & ~xtal_stop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase + age since phase entry; outputs follow from the phase alone.
    int m_phase, m_age, m_good, m_fails, m_win, m_last_edge, m_ready_at, cyc, e_count;
    logic [4:0] hist;
    logic sedge, closing, bad, loss;

    task automatic enter(input int p);
        m_phase = p;
        m_age   = 0;
        m_win   = 0;
        if (p == P_READY) m_ready_at = cyc;
        if (p == P_MEAS) m_good = 0;
        if (p == P_OFF || p == P_READY) m_fails = 0;
    endtask

    task automatic fail_attempt();
        if (m_fails == RMAX) enter(P_FAULT);
        else begin
            m_fails++;
            enter(P_START);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = P_OFF; m_age = 0; m_good = 0; m_fails = 0; m_win = 0;
            m_last_edge = 0; m_ready_at = 0; cyc = 0; e_count = 0; hist = '0;
        end else begin
            cyc++;
            hist  = {hist[3:0], xtal_dout};
            sedge = hist[3] & ~hist[4];
            if (sedge) m_last_edge = cyc;
            m_age++;
            if (!en_req) enter(P_OFF);
            else begin
                case (m_phase)
                    P_OFF:   enter(P_START);
                    P_START: if (m_age == STARTUP) enter(P_MEAS);
                    P_MEAS, P_READY: begin
                        m_win  += int'(sedge);
                        closing = ((m_age % WIN) == 0);
                        bad     = 1'b0;
                        if (closing) begin
                            e_count = (m_win > CMAX) ? CMAX : m_win;
                            bad     = (e_count < EMIN) || (e_count > EMAX);
                            m_win   = 0;
                        end
                        if (m_phase == P_MEAS) begin
                            if (closing) begin
                                if (bad) fail_attempt();
                                else begin
                                    m_good++;
                                    if (m_good == GOOD) enter(P_READY);
                                end
                            end
                        end else begin
                            loss = (cyc - ((m_last_edge > m_ready_at) ? m_last_edge : m_ready_at)) >= LOSS;
                            if (loss || bad) fail_attempt();
                            else if (stdby_req) enter(P_STDBY);
                        end
                    end
                    P_STDBY: if (!stdby_req) enter(P_START);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_phase);
        chk("xtal_ena", xtal_ena, (m_phase >= P_START && m_phase <= P_STDBY));
        chk("xtal_stdby", xtal_stdby, (m_phase == P_STDBY));
        chk("clk_ready", clk_ready, (m_phase == P_READY));
        chk("fault", fault, (m_phase == P_FAULT));
        chk("edge_count", edge_count, e_count);
        if (clk_ready) saw_ready = 1'b1;
    end

    task automatic wait_ready(input int budget, input string nm);
        int n = 0;
        while (clk_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, clk_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_ena", xtal_ena, 0);
        chk("reset_edge_count", edge_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: qualification at 16 MHz
        en_req = 1'b1;
        @(negedge clk);
        chk("t1_ena_after_1", xtal_ena, 1);
        chk("t1_state_start", state, 1);
        repeat (319) @(negedge clk);
        chk("t1_not_ready_yet", clk_ready, 0);
        @(negedge clk);
        chk("t1_ready_at_320", clk_ready, 1);
        chk("t1_edge_count_range", (edge_count >= 20 && edge_count <= 21), 1);
        chk("t1_fault", fault, 0);

        // 2: loss of clock in READY
        repeat (10) @(negedge clk);
        xtal_stop = 1'b1;
        for (int i = 0; i < LOSS + 4 && clk_ready; i++) @(negedge clk);
        chk("t2_ready_dropped", clk_ready, 0);
        chk("t2_state_start", state, 1);
        xtal_stop = 1'b0;
        wait_ready(400, "t2_requalify");

        // 4: standby round trip
        repeat (5) @(negedge clk);
        stdby_req = 1'b1;
        @(negedge clk);
        chk("t4_stdby_on", xtal_stdby, 1);
        chk("t4_ready_off", clk_ready, 0);
        chk("t4_state_stdby", state, 4);
        repeat (5) @(negedge clk);
        stdby_req = 1'b0;
        @(negedge clk);
        chk("t4_stdby_off", xtal_stdby, 0);
        chk("t4_state_start", state, 1);
        wait_ready(400, "t4_requalify");

        // 3: 8 MHz crystal exhausts retries
        en_req = 1'b0;
        @(negedge clk);
        chk("t3_off", state, 0);
        half_ns = 62.5;
        en_req = 1'b1;
        repeat (512) @(negedge clk);
        chk("t3_no_fault_yet", fault, 0);
        @(negedge clk);
        chk("t3_fault", fault, 1);
        chk("t3_state_fault", state, 5);
        chk("t3_ena_low", xtal_ena, 0);
        chk("t3_edge_count_range", (edge_count >= 9 && edge_count <= 11), 1);
        en_req = 1'b0;
        @(negedge clk);
        chk("t3_fault_cleared", fault, 0);
        chk("t3_state_off", state, 0);
        half_ns = 31.25;

        // 5: async reset mid-MEASURE, then en_req drop in START
        en_req = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_in_measure", state, 2);
        #3 resetn = 1'b0;
        #1;
        chk("t5_async_state", state, 0);
        chk("t5_async_ena", xtal_ena, 0);
        chk("t5_async_edge_count", edge_count, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_restart", state, 1);
        repeat (5) @(negedge clk);
        en_req = 1'b0;
        @(negedge clk);
        chk("t5_off_next", state, 0);
        chk("t5_ena_off", xtal_ena, 0);

        // 6: en_req drop coincides with the qualifying window end
        saw_ready = 1'b0;
        en_req = 1'b1;
        repeat (320) @(negedge clk);
        en_req = 1'b0;
        @(negedge clk);
        chk("t6_state_off", state, 0);
        chk("t6_never_ready", saw_ready, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
